// File: rtl/rng_pkg.sv
// Shared types and the LFSR step function for the random-number scheduler.
package rng_pkg;

    typedef enum logic [1:0] {IDLE, STEP, DELIVER} state_t;

    localparam int         LFSR_W   = 8;
    localparam logic [7:0] TAP_MASK = 8'h55;

    // Bit 7 is deliberately excluded from the feedback taps.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] value);
        return {value[LFSR_W-2:0], ^(value & TAP_MASK)};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int PW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    grant_idx,
    output logic             any_req
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant_idx = '0;
        any_req   = |req;
        sum       = '0;
        idx       = '0;
        found     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = (PW+1)'(ptr) + (PW+1)'(i);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            idx = PW'(sum);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/rng_scheduler.sv
// Shares one 8-bit LFSR among N_REQ requesters with round-robin grants,
// a fixed number of LFSR steps per grant, and a deferred reseed path.
module rng_scheduler
    import rng_pkg::*;
#(
    parameter int         N_REQ = 4,
    parameter int         STEPS = 2,
    parameter logic [7:0] SEED  = 8'hAA
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [7:0]       rand_out,
    output logic             rand_valid,
    input  logic             seed_load,
    input  logic [7:0]       seed_in,
    output logic             busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(STEPS + 1);

    state_t         state;
    state_t         state_next;
    logic [7:0]     lfsr;
    logic [7:0]     seed_reg;
    logic           seed_pending;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  grant_idx;
    logic [PW-1:0]  arb_idx;
    logic           any_req;
    logic [CW-1:0]  step_cnt;
    logic           last_step;

    rr_arbiter #(.N_REQ(N_REQ)) u_arbiter (
        .req       (req),
        .ptr       (rr_ptr),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

    assign last_step = (step_cnt == CW'(STEPS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pending reseed wins over arbitration, so IDLE only advances without one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!seed_pending && any_req) state_next = STEP;
            STEP:    if (last_step)                state_next = DELIVER;
            DELIVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr         <= SEED;
            seed_reg     <= '0;
            seed_pending <= 1'b0;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            step_cnt     <= '0;
            ack          <= '0;
            rand_valid   <= 1'b0;
            rand_out     <= '0;
        end else begin
            ack        <= '0;
            rand_valid <= 1'b0;

            if (seed_load) begin
                seed_reg <= seed_in;
            end

            // A fresh strobe keeps the flag set even on the cycle the older seed is applied.
            if (seed_load) begin
                seed_pending <= 1'b1;
            end else if (state == IDLE) begin
                seed_pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (seed_pending) begin
                        lfsr <= (seed_reg == 8'h00) ? SEED : seed_reg;
                    end else if (any_req) begin
                        grant_idx <= arb_idx;
                        step_cnt  <= '0;
                    end
                end
                STEP: begin
                    lfsr     <= lfsr_next(lfsr);
                    step_cnt <= step_cnt + 1'b1;
                end
                DELIVER: begin
                    rand_out       <= lfsr;
                    rand_valid     <= 1'b1;
                    ack[grant_idx] <= 1'b1;
                    rr_ptr         <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
